daq_depacketizer: RTL and testbench

- Reader at the far end of the DAQ packet FIFO. It pops the 8-bit FIFO read port and hunts for the 16'hAAAA preamble.
- It reassembles 16-bit ADC words and presents each one on a valid/ready sample interface, tagged with its device index and channel index.
- It sits in the host/USB clock domain, on the FIFO read side, and feeds downstream framing or transfer logic.

---
 rtl/daq_depacketizer.sv | 197 +++++++++++++++++++
 tb/tb_daq_depacketizer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/daq_depacketizer.sv
// -----------------------------------------------------------------------------
// daq_depacketizer
//
// Purpose:
//   Drains the DAQ packet FIFO one byte at a time, hunts for the frame
//   preamble, and rebuilds 16-bit ADC words (low byte first). Each word is
//   presented on a valid/ready sample interface, tagged with its device and
//   channel index. Frame completion is counted when the last sample of a
//   frame is accepted downstream.
//
// Ports:
//   clk_i           clock (same as the FIFO read clock)
//   reset_i         asynchronous, active-low reset
//   fifo_empty_i    FIFO read-side empty flag
//   fifo_req_o      FIFO read request (one byte popped per high cycle)
//   fifo_data_i     FIFO read data, valid the cycle after fifo_req_o
//   sample_o        reassembled ADC word
//   sample_valid_o  sample_o / daq_idx_o / ch_idx_o / frame_start_o valid
//   sample_ready_i  downstream accept
//   daq_idx_o       device index of the presented sample
//   ch_idx_o        channel index of the presented sample
//   frame_start_o   high with the first sample of a frame
//   frame_done_o    1-cycle pulse when the last sample of a frame is accepted
//   sync_err_o      1-cycle pulse when an expected preamble is missing
//   locked_o        high while aligned to the frame structure
//   frame_cnt_o     completed-frame counter (wraps)
// -----------------------------------------------------------------------------
module daq_depacketizer #(
  parameter int          ADCCOUNT    = 8,
  parameter int          DAQCOUNT    = 4,
  parameter logic [15:0] PREAMBLE    = 16'hAAAA,
  parameter int          FRAME_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   fifo_empty_i,
  output logic                   fifo_req_o,
  input  logic [7:0]             fifo_data_i,
  output logic [15:0]            sample_o,
  output logic                   sample_valid_o,
  input  logic                   sample_ready_i,
  output logic [2:0]             daq_idx_o,
  output logic [2:0]             ch_idx_o,
  output logic                   frame_start_o,
  output logic                   frame_done_o,
  output logic                   sync_err_o,
  output logic                   locked_o,
  output logic [FRAME_CNT_W-1:0] frame_cnt_o
);

  typedef enum logic [2:0] {
    S_HUNT0,  // looking for preamble low byte
    S_HUNT1,  // looking for preamble high byte
    S_DLO,    // expecting a data low byte
    S_DHI,    // expecting a data high byte
    S_PLO,    // expecting next frame's preamble low byte
    S_PHI     // expecting next frame's preamble high byte
  } state_e;

  localparam logic [2:0] CH_LAST  = 3'(ADCCOUNT - 1);
  localparam logic [2:0] DAQ_LAST = 3'(DAQCOUNT - 1);

  state_e                 state_q;
  logic                   rd_pend_q;   // a popped byte arrives on fifo_data_i this cycle
  logic [7:0]             lo_q;        // low byte of the word being assembled
  logic [2:0]             ch_q;        // channel index of the word being assembled
  logic [2:0]             daq_q;       // device index of the word being assembled
  logic                   word_last;   // word being assembled is the frame's last

  logic [15:0]            sample_q;
  logic                   valid_q;
  logic [2:0]             daq_out_q;
  logic [2:0]             ch_out_q;
  logic                   fstart_q;
  logic                   last_q;      // held sample is the last of its frame
  logic                   done_q;
  logic                   err_q;
  logic                   locked_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;

  // Only one byte in flight, and no new pop while the output register is
  // occupied and not being drained, so a completed word always has a free
  // output slot to land in.
  assign fifo_req_o = reset_i && !fifo_empty_i && !rd_pend_q &&
                      (!valid_q || sample_ready_i);

  assign word_last = (daq_q == DAQ_LAST) && (ch_q == CH_LAST);

  // NOTE: all state here is sequential, so every assignment is non-blocking;
  // later assignments in the same cycle override earlier ones, which is how
  // a newly completed word wins over the "drop valid after accept" below.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= S_HUNT0;
      rd_pend_q   <= 1'b0;
      lo_q        <= '0;
      ch_q        <= '0;
      daq_q       <= '0;
      sample_q    <= '0;
      valid_q     <= 1'b0;
      daq_out_q   <= '0;
      ch_out_q    <= '0;
      fstart_q    <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      locked_q    <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      rd_pend_q <= fifo_req_o;
      done_q    <= 1'b0;
      err_q     <= 1'b0;

      // Output handshake; frames are counted on acceptance, not assembly.
      if (valid_q && sample_ready_i) begin
        valid_q <= 1'b0;
        if (last_q) begin
          done_q      <= 1'b1;
          frame_cnt_q <= frame_cnt_q + 1'b1;
        end
      end

      if (rd_pend_q) begin
        unique case (state_q)
          S_HUNT0: begin
            if (fifo_data_i == PREAMBLE[7:0]) state_q <= S_HUNT1;
          end
          S_HUNT1: begin
            if (fifo_data_i == PREAMBLE[15:8]) begin
              state_q  <= S_DLO;
              locked_q <= 1'b1;
              ch_q     <= '0;
              daq_q    <= '0;
            end else begin
              state_q <= S_HUNT0;
            end
          end
          S_DLO: begin
            lo_q    <= fifo_data_i;
            state_q <= S_DHI;
          end
          S_DHI: begin
            sample_q  <= {fifo_data_i, lo_q};
            daq_out_q <= daq_q;
            ch_out_q  <= ch_q;
            fstart_q  <= (daq_q == 3'd0) && (ch_q == 3'd0);
            last_q    <= word_last;
            valid_q   <= 1'b1;
            if (word_last) begin
              state_q <= S_PLO;
            end else begin
              state_q <= S_DLO;
              if (ch_q == CH_LAST) begin
                ch_q  <= '0;
                daq_q <= daq_q + 3'd1;
              end else begin
                ch_q <= ch_q + 3'd1;
              end
            end
          end
          S_PLO: begin
            if (fifo_data_i == PREAMBLE[7:0]) begin
              state_q <= S_PHI;
            end else begin
              err_q    <= 1'b1;
              locked_q <= 1'b0;
              state_q  <= S_HUNT0;
            end
          end
          S_PHI: begin
            if (fifo_data_i == PREAMBLE[15:8]) begin
              state_q <= S_DLO;
              ch_q    <= '0;
              daq_q   <= '0;
            end else begin
              err_q    <= 1'b1;
              locked_q <= 1'b0;
              state_q  <= S_HUNT0;
            end
          end
          default: state_q <= S_HUNT0;
        endcase
      end
    end
  end

  assign sample_o       = sample_q;
  assign sample_valid_o = valid_q;
  assign daq_idx_o      = daq_out_q;
  assign ch_idx_o       = ch_out_q;
  assign frame_start_o  = fstart_q;
  assign frame_done_o   = done_q;
  assign sync_err_o     = err_q;
  assign locked_o       = locked_q;
  assign frame_cnt_o    = frame_cnt_q;

endmodule

// File: tb/tb_daq_depacketizer.sv
// -----------------------------------------------------------------------------
// tb_daq_depacketizer
//
// Directed bench: a byte queue models the FIFO (data one cycle after the
// request), a negedge monitor records every accepted sample and counts
// frame_done / sync_err pulses, and one initial block walks the scenarios.
// -----------------------------------------------------------------------------
module tb_daq_depacketizer;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        fifo_empty_i = 1'b1;
  logic        fifo_req_o;
  logic [7:0]  fifo_data_i = 8'h00;
  logic [15:0] sample_o;
  logic        sample_valid_o;
  logic        sample_ready_i = 1'b1;
  logic [2:0]  daq_idx_o;
  logic [2:0]  ch_idx_o;
  logic        frame_start_o;
  logic        frame_done_o;
  logic        sync_err_o;
  logic        locked_o;
  logic [15:0] frame_cnt_o;

  daq_depacketizer dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .fifo_empty_i   (fifo_empty_i),
    .fifo_req_o     (fifo_req_o),
    .fifo_data_i    (fifo_data_i),
    .sample_o       (sample_o),
    .sample_valid_o (sample_valid_o),
    .sample_ready_i (sample_ready_i),
    .daq_idx_o      (daq_idx_o),
    .ch_idx_o       (ch_idx_o),
    .frame_start_o  (frame_start_o),
    .frame_done_o   (frame_done_o),
    .sync_err_o     (sync_err_o),
    .locked_o       (locked_o),
    .frame_cnt_o    (frame_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [15:0] sample;
    logic [2:0]  daq;
    logic [2:0]  ch;
    logic        fs;
  } rec_t;

  rec_t       rec[$];
  logic [7:0] byte_q[$];
  int         n_tests  = 0;
  int         n_fail   = 0;
  int         done_cnt = 0;
  int         err_cnt  = 0;

  // FIFO model: pop on request, data visible the following cycle.
  always @(posedge clk_i) begin
    if (fifo_req_o && byte_q.size() > 0) fifo_data_i <= byte_q.pop_front();
  end

  // Monitor away from the active edge.
  always @(negedge clk_i) begin
    fifo_empty_i = (byte_q.size() == 0);
    if (sample_valid_o && sample_ready_i)
      rec.push_back({sample_o, daq_idx_o, ch_idx_o, frame_start_o});
    if (frame_done_o) done_cnt++;
    if (sync_err_o)   err_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic push_frame(input logic [15:0] base);
    logic [15:0] w;
    byte_q.push_back(8'hAA);
    byte_q.push_back(8'hAA);
    for (int n = 0; n < 32; n++) begin
      w = base + 16'(n);
      byte_q.push_back(w[7:0]);
      byte_q.push_back(w[15:8]);
    end
  endtask

  task automatic wait_samples(input int target);
    int cyc = 0;
    while (rec.size() < target && cyc < 2000) begin
      tick(1);
      cyc++;
    end
    tick(6);
    check("sample_count", 64'(rec.size()), 64'(target));
  endtask

  task automatic check_frame(input int k, input logic [15:0] base, input int first);
    rec_t exp_r;
    rec_t obs_r;
    for (int n = 0; n < 32; n++) begin
      exp_r = {base + 16'(n), 3'(n / 8), 3'(n % 8), (n == 0)};
      obs_r = (first + n < rec.size()) ? rec[first + n] : '1;
      check($sformatf("f%0d_s%0d", k, n), 64'(obs_r), 64'(exp_r));
    end
  endtask

  initial begin
    int cyc;
    logic [15:0] held;

    // ---- reset with data waiting in the FIFO ----
    push_frame(16'h0100);
    tick(3);
    check("req_in_reset", 64'(fifo_req_o), 64'd0);
    check("outs_in_reset",
          64'({sample_valid_o, frame_done_o, sync_err_o, locked_o, frame_cnt_o,
               sample_o, daq_idx_o, ch_idx_o, frame_start_o}), 64'd0);
    reset_i = 1'b1;
    #1;
    check("req_after_release", 64'(fifo_req_o), 64'd1);

    // ---- frame 0: ready always high ----
    wait_samples(32);
    check_frame(0, 16'h0100, 0);
    check("f0_done_cnt", 64'(done_cnt), 64'd1);
    check("f0_frame_cnt", 64'(frame_cnt_o), 64'd1);
    check("f0_err_cnt", 64'(err_cnt), 64'd0);
    check("f0_locked", 64'(locked_o), 64'd1);

    // ---- frame 1: backpressure on sample 5 for 10 cycles ----
    push_frame(16'h2200);
    cyc = 0;
    while (rec.size() < 37 && cyc < 2000) begin tick(1); cyc++; end
    sample_ready_i = 1'b0;
    cyc = 0;
    while (!sample_valid_o && cyc < 100) begin tick(1); cyc++; end
    held = sample_o;
    check("stall_sample", 64'(held), 64'h2205);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check($sformatf("stall_c%0d", i),
            64'({fifo_req_o, sample_valid_o, sample_o}), 64'({1'b0, 1'b1, 16'h2205}));
    end
    sample_ready_i = 1'b1;
    wait_samples(64);
    check_frame(1, 16'h2200, 32);
    check("f1_done_cnt", 64'(done_cnt), 64'd2);
    check("f1_frame_cnt", 64'(frame_cnt_o), 64'd2);

    // ---- bad next header (0x55), then relock ----
    byte_q.push_back(8'h55);
    tick(8);
    check("bad_hdr_err_cnt", 64'(err_cnt), 64'd1);
    check("bad_hdr_locked", 64'(locked_o), 64'd0);
    // Rest of the bad header (AA), a non-preamble filler so hunting restarts
    // cleanly, then a well-formed frame.
    byte_q.push_back(8'hAA);
    byte_q.push_back(8'h00);
    push_frame(16'h3300);
    wait_samples(96);
    check_frame(2, 16'h3300, 64);
    check("f2_done_cnt", 64'(done_cnt), 64'd3);
    check("f2_frame_cnt", 64'(frame_cnt_o), 64'd3);
    check("f2_err_cnt", 64'(err_cnt), 64'd1);
    check("f2_locked", 64'(locked_o), 64'd1);

    // ---- reset in the middle of a word (after its low byte) ----
    byte_q.push_back(8'hAA);
    byte_q.push_back(8'hAA);
    byte_q.push_back(8'h34);
    tick(10);
    check("partial_no_sample", 64'(rec.size()), 64'd96);
    reset_i = 1'b0;
    #2;
    check("midreset_outs",
          64'({fifo_req_o, sample_valid_o, locked_o, frame_cnt_o, sample_o}), 64'd0);
    tick(2);
    reset_i = 1'b1;

    // ---- leading garbage 12 AA 34, then AA AA + frame ----
    byte_q.push_back(8'h12);
    byte_q.push_back(8'hAA);
    byte_q.push_back(8'h34);
    push_frame(16'h4400);
    wait_samples(128);
    check_frame(3, 16'h4400, 96);
    check("f3_done_cnt", 64'(done_cnt), 64'd4);
    check("f3_frame_cnt", 64'(frame_cnt_o), 64'd1);
    check("f3_err_cnt", 64'(err_cnt), 64'd1);
    check("f3_locked", 64'(locked_o), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
